branch_prediction_two_level: RTL and testbench

//  Two-level branch predictor, successor to the fixed local predictor: per-branch local

---
 rtl/branch_prediction_two_level.sv | 139 +++++++++++++
 tb/tb_branch_prediction_two_level.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_prediction_two_level.sv
// Two-level branch predictor: a per-branch local history table (BHT) selects a
// saturating counter in the pattern history table (PHT). MODE 1 folds the
// global history register (GHR) into the index gshare-style. The PHT index used
// for each prediction is returned so execute can update exactly that counter.
//
// Handshake: valid-only, no ready. predict_valid/renew_valid are each accepted
// on every rising edge at which they are high; predict_out_valid pulses for one
// cycle, one cycle after an accepted request. predict_result/predict_index hold
// their last value while predict_out_valid is low.
module branch_prediction_two_level #(
    parameter int LOW_ADDR_WIDTH       = 8,
    parameter int BRANCH_HISTORY_WIDTH = 4,
    parameter int COUNTER_WIDTH        = 2,
    parameter int MODE                 = 0,
    parameter int STAT_WIDTH           = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            predict_valid,
    input  logic [LOW_ADDR_WIDTH-1:0]       predict_addr,
    output logic                            predict_out_valid,
    output logic                            predict_result,
    output logic [BRANCH_HISTORY_WIDTH-1:0] predict_index,
    input  logic                            renew_valid,
    input  logic [LOW_ADDR_WIDTH-1:0]       renew_addr,
    input  logic [BRANCH_HISTORY_WIDTH-1:0] renew_index,
    input  logic                            renew_last_predict,
    input  logic                            renew_result,
    output logic [STAT_WIDTH-1:0]           stat_branch_cnt,
    output logic [STAT_WIDTH-1:0]           stat_miss_cnt
);

    localparam int HW        = BRANCH_HISTORY_WIDTH;
    localparam int CW        = COUNTER_WIDTH;
    localparam int BHT_DEPTH = 1 << LOW_ADDR_WIDTH;
    localparam int PHT_DEPTH = 1 << HW;
    // Weak not-taken: MSB clear, all lower bits set (0 when CW == 1).
    localparam logic [CW-1:0] PHT_INIT = CW'((1 << (CW - 1)) - 1);
    localparam logic [CW-1:0] PHT_MAX  = '1;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    logic [HW-1:0] bht_q [BHT_DEPTH];
    logic [CW-1:0] pht_q [PHT_DEPTH];
    logic [HW-1:0] ghr_q;

    logic [HW-1:0] pred_idx;
    logic [HW-1:0] bht_next;
    logic [HW-1:0] ghr_next;
    logic [CW-1:0] cnt_cur;
    logic [CW-1:0] cnt_next;

    // Prediction index from pre-update state; there is deliberately no bypass
    // from a same-cycle renew.
    always_comb begin
        pred_idx = bht_q[predict_addr];
        if (MODE != 0) begin
            pred_idx = bht_q[predict_addr] ^ ghr_q;
        end
    end

    // Next history values: shift left, outcome enters at bit 0. Written as a
    // shift plus bit set so that a one-bit history simply becomes the outcome.
    always_comb begin
        bht_next    = bht_q[renew_addr] << 1;
        bht_next[0] = renew_result;
        ghr_next    = ghr_q << 1;
        ghr_next[0] = renew_result;
    end

    // Saturating counter step driven only by the actual outcome.
    always_comb begin
        cnt_cur  = pht_q[renew_index];
        cnt_next = cnt_cur;
        if (renew_result) begin
            if (cnt_cur != PHT_MAX) begin
                cnt_next = cnt_cur + CW'(1);
            end
        end else begin
            if (cnt_cur != '0) begin
                cnt_next = cnt_cur - CW'(1);
            end
        end
    end

    // Registered prediction outputs; reset drops any request in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            predict_out_valid <= 1'b0;
            predict_result    <= 1'b0;
            predict_index     <= '0;
        end else begin
            predict_out_valid <= predict_valid;
            if (predict_valid) begin
                predict_index  <= pred_idx;
                predict_result <= pht_q[pred_idx][CW-1];
            end
        end
    end

    // Local and global history update on resolve.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= '0;
            end
            ghr_q <= '0;
        end else if (renew_valid) begin
            bht_q[renew_addr] <= bht_next;
            ghr_q             <= ghr_next;
        end
    end

    // Pattern table update at the index the core carried down the pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i] <= PHT_INIT;
            end
        end else if (renew_valid) begin
            pht_q[renew_index] <= cnt_next;
        end
    end

    // Saturating branch and mispredict statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branch_cnt <= '0;
            stat_miss_cnt   <= '0;
        end else if (renew_valid) begin
            if (stat_branch_cnt != STAT_MAX) begin
                stat_branch_cnt <= stat_branch_cnt + STAT_WIDTH'(1);
            end
            if ((renew_last_predict != renew_result) && (stat_miss_cnt != STAT_MAX)) begin
                stat_miss_cnt <= stat_miss_cnt + STAT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_prediction_two_level.sv
// Bench for branch_prediction_two_level. Two instances share one stimulus
// stream: u_m0 (MODE 0, 32-bit stats) and u_m1 (MODE 1, 3-bit stats). Both see
// identical renews, so one reference model of histories and counters serves
// both; only the prediction index and the statistic saturation differ.
module tb_branch_prediction_two_level;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       predict_valid = 1'b0;
    logic [7:0] predict_addr = '0;
    logic       renew_valid = 1'b0;
    logic [7:0] renew_addr = '0;
    logic [3:0] renew_index = '0;
    logic       renew_last_predict = 1'b0;
    logic       renew_result = 1'b0;

    logic        m0_out_valid, m0_result;
    logic [3:0]  m0_index;
    logic [31:0] m0_branch, m0_miss;
    logic        m1_out_valid, m1_result;
    logic [3:0]  m1_index;
    logic [2:0]  m1_branch, m1_miss;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    branch_prediction_two_level #(
        .LOW_ADDR_WIDTH(8), .BRANCH_HISTORY_WIDTH(4), .COUNTER_WIDTH(2),
        .MODE(0), .STAT_WIDTH(32)
    ) u_m0 (
        .clk(clk), .rst_n(rst_n),
        .predict_valid(predict_valid), .predict_addr(predict_addr),
        .predict_out_valid(m0_out_valid), .predict_result(m0_result),
        .predict_index(m0_index),
        .renew_valid(renew_valid), .renew_addr(renew_addr),
        .renew_index(renew_index), .renew_last_predict(renew_last_predict),
        .renew_result(renew_result),
        .stat_branch_cnt(m0_branch), .stat_miss_cnt(m0_miss)
    );

    branch_prediction_two_level #(
        .LOW_ADDR_WIDTH(8), .BRANCH_HISTORY_WIDTH(4), .COUNTER_WIDTH(2),
        .MODE(1), .STAT_WIDTH(3)
    ) u_m1 (
        .clk(clk), .rst_n(rst_n),
        .predict_valid(predict_valid), .predict_addr(predict_addr),
        .predict_out_valid(m1_out_valid), .predict_result(m1_result),
        .predict_index(m1_index),
        .renew_valid(renew_valid), .renew_addr(renew_addr),
        .renew_index(renew_index), .renew_last_predict(renew_last_predict),
        .renew_result(renew_result),
        .stat_branch_cnt(m1_branch), .stat_miss_cnt(m1_miss)
    );

    // ---------------- reference model ----------------
    // Histories as integers (newest outcome is the least significant bit),
    // counters as integers clamped to 0..3, statistics as clamped integers.
    int    m_bht [256];
    int    m_pht [16];
    int    m_ghr;
    longint m_br0, m_ms0, m_br1, m_ms1;
    int    e_valid, e_res0, e_idx0, e_res1, e_idx1;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_bht[i] = 0;
        for (int i = 0; i < 16; i++) m_pht[i] = 1;
        m_ghr = 0;
        m_br0 = 0; m_ms0 = 0; m_br1 = 0; m_ms1 = 0;
        e_valid = 0; e_res0 = 0; e_idx0 = 0; e_res1 = 0; e_idx1 = 0;
    endtask

    task automatic check_all(input string where);
        check({where, ":m0_valid"}, 64'(m0_out_valid), 64'(e_valid));
        check({where, ":m0_result"}, 64'(m0_result), 64'(e_res0));
        check({where, ":m0_index"}, 64'(m0_index), 64'(e_idx0));
        check({where, ":m0_branch"}, 64'(m0_branch), 64'(m_br0));
        check({where, ":m0_miss"}, 64'(m0_miss), 64'(m_ms0));
        check({where, ":m1_valid"}, 64'(m1_out_valid), 64'(e_valid));
        check({where, ":m1_result"}, 64'(m1_result), 64'(e_res1));
        check({where, ":m1_index"}, 64'(m1_index), 64'(e_idx1));
        check({where, ":m1_branch"}, 64'(m1_branch), 64'(m_br1));
        check({where, ":m1_miss"}, 64'(m1_miss), 64'(m_ms1));
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge: drive, predict expectations from the
    // pre-edge model, apply renew to the model, then sample 1 ns after the edge.
    task automatic cycle(input string where, input logic pv, input int pa,
                         input logic rv, input int ra, input int ri,
                         input logic rlp, input logic rr);
        int h;
        predict_valid      = pv;
        predict_addr       = 8'(pa);
        renew_valid        = rv;
        renew_addr         = 8'(ra);
        renew_index        = 4'(ri);
        renew_last_predict = rlp;
        renew_result       = rr;
        if (pv) begin
            h       = m_bht[pa];
            e_valid = 1;
            e_idx0  = h;
            e_idx1  = h ^ m_ghr;
            e_res0  = (m_pht[e_idx0] >= 2) ? 1 : 0;
            e_res1  = (m_pht[e_idx1] >= 2) ? 1 : 0;
        end else begin
            e_valid = 0;
        end
        if (rv) begin
            m_bht[ra] = (m_bht[ra] * 2 + int'(rr)) % 16;
            m_ghr     = (m_ghr * 2 + int'(rr)) % 16;
            if (rr) m_pht[ri] = (m_pht[ri] < 3) ? m_pht[ri] + 1 : 3;
            else    m_pht[ri] = (m_pht[ri] > 0) ? m_pht[ri] - 1 : 0;
            m_br0 = (m_br0 < 64'hFFFF_FFFF) ? m_br0 + 1 : m_br0;
            m_br1 = (m_br1 < 7) ? m_br1 + 1 : m_br1;
            if (rlp != rr) begin
                m_ms0 = (m_ms0 < 64'hFFFF_FFFF) ? m_ms0 + 1 : m_ms0;
                m_ms1 = (m_ms1 < 7) ? m_ms1 + 1 : m_ms1;
            end
        end
        @(posedge clk);
        #1;
        check_all(where);
        @(negedge clk);
    endtask

    task automatic renew(input string where, input int ra, input int ri,
                         input logic rlp, input logic rr);
        cycle(where, 1'b0, 0, 1'b1, ra, ri, rlp, rr);
    endtask

    task automatic predict(input string where, input int pa);
        cycle(where, 1'b1, pa, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // Reset with a predict request asserted: it must be discarded.
    task automatic do_reset(input string where);
        rst_n         = 1'b0;
        predict_valid = 1'b1;
        predict_addr  = 8'h05;
        renew_valid   = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_all(where);
        @(negedge clk);
        rst_n         = 1'b1;
        predict_valid = 1'b0;
        renew_valid   = 1'b0;
    endtask

    // ---------------- sequence ----------------
    initial begin
        model_reset();
        @(negedge clk);
        do_reset("reset0");

        // Cold predict: weak not-taken at index 0.
        predict("cold", 8'h05);

        // Two taken renews on idx 0: PHT[0]=3, BHT[0x05]=0011.
        renew("t2_r", 8'h05, 0, 1'b0, 1'b1);
        renew("t2_r", 8'h05, 0, 1'b0, 1'b1);
        predict("t2_p", 8'h05);
        check("t2_dir_index", 64'(m0_index), 64'd3);
        check("t2_dir_result", 64'(m0_result), 64'd0);

        // Counter saturation on idx 7.
        for (int i = 0; i < 5; i++) renew("t3_up", 8'h40, 7, 1'b1, 1'b1);
        renew("t3_dn1", 8'h40, 7, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) renew("t3_dn", 8'h40, 7, 1'b0, 1'b0);

        // Build BHT[0x10]=0110 then GHR=1010 for the gshare index.
        do_reset("reset1");
        renew("t4_b", 8'h10, 0, 1'b0, 1'b0);
        renew("t4_b", 8'h10, 0, 1'b0, 1'b1);
        renew("t4_b", 8'h10, 0, 1'b0, 1'b1);
        renew("t4_b", 8'h10, 0, 1'b0, 1'b0);
        renew("t4_g", 8'h11, 0, 1'b0, 1'b1);
        renew("t4_g", 8'h11, 0, 1'b0, 1'b0);
        renew("t4_g", 8'h11, 0, 1'b0, 1'b1);
        renew("t4_g", 8'h11, 0, 1'b0, 1'b0);
        predict("t4_p", 8'h10);
        check("t4_dir_m1_index", 64'(m1_index), 64'hC);
        check("t4_dir_m0_index", 64'(m0_index), 64'h6);

        // Same-cycle predict and renew on 0x22: old history first, new next.
        cycle("t5_same", 1'b1, 8'h22, 1'b1, 8'h22, 3, 1'b0, 1'b1);
        check("t5_dir_old", 64'(m0_index), 64'd0);
        predict("t5_next", 8'h22);
        check("t5_dir_new", 64'(m0_index), 64'd1);

        // Statistic saturation on the 3-bit instance.
        do_reset("reset2");
        for (int i = 0; i < 9; i++) renew("t6_miss", 8'h33, 2, 1'b1, 1'b0);
        check("t6_dir_miss", 64'(m1_miss), 64'd7);
        check("t6_dir_branch", 64'(m1_branch), 64'd7);
        check("t6_dir_m0_miss", 64'(m0_miss), 64'd9);
        do_reset("reset3");

        // Randomized traffic with a narrow address set to force collisions.
        for (int n = 0; n < 1500; n++) begin
            int pa, ra;
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rand_reset");
            end else begin
                pa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                 : int'($urandom_range(0, 7));
                ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                 : int'($urandom_range(0, 7));
                cycle("rand", 1'($urandom_range(0, 1)), pa,
                      1'($urandom_range(0, 1)), ra, int'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
